// File: rtl/jt7759_feeder_if.sv
// jt7759_feeder_if: ROM fetch port plus JT7759 slave-mode byte write port
interface jt7759_feeder_if;
  logic        rom_cs;
  logic [16:0] rom_addr;
  logic [7:0]  rom_data;
  logic        rom_ok;
  logic        drqn;
  logic        cs;
  logic        wrn;
  logic [7:0]  dout;
  modport master (
    output rom_cs, rom_addr, cs, wrn, dout,
    input  rom_data, rom_ok, drqn
  );
  modport slave (
    input  rom_cs, rom_addr, cs, wrn, dout,
    output rom_data, rom_ok, drqn
  );
endinterface

// File: rtl/jt7759_feeder.sv
// jt7759_feeder: streams a ROM block into the JT7759 slave port, one write strobe per drqn request
module jt7759_feeder #(
  parameter int unsigned STRB = 4
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            cen,
  input  logic            start,
  input  logic            stop,
  input  logic [16:0]     start_addr,
  input  logic [16:0]     len,
  output logic            busy,
  output logic            done,
  jt7759_feeder_if.master bus
);
  typedef enum logic [1:0] {ST_IDLE, ST_ARM, ST_STRB, ST_REL} state_t;
  state_t      state_q, state_d;
  logic [16:0] fetch_q, fetch_d, send_q, send_d, addr_q, addr_d;
  logic [3:0]  strb_q, strb_d;
  logic [7:0]  mem_q [2];
  logic [7:0]  mem_d [2];
  logic        wp_q, wp_d, rp_q, rp_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        cap_q, cap_d, cs_q, cs_d, wrn_q, wrn_d, done_q, done_d;
  logic [7:0]  dout_q, dout_d;
  logic        push, pop;
  assign busy         = state_q != ST_IDLE;
  assign done         = done_q;
  assign bus.rom_cs   = busy && cnt_q != 2'd2 && fetch_q != 17'd0 && !cap_q;
  assign bus.rom_addr = addr_q;
  assign bus.cs       = cs_q;
  assign bus.wrn      = wrn_q;
  assign bus.dout     = dout_q;
  assign push         = bus.rom_cs && bus.rom_ok;
  // next state: ROM capture into the FIFO, send-side FSM on cen, stop overrides all
  always_comb begin
    state_d = state_q;
    fetch_d = fetch_q;
    send_d  = send_q;
    addr_d  = addr_q;
    strb_d  = strb_q;
    mem_d   = mem_q;
    wp_d    = wp_q;
    rp_d    = rp_q;
    cap_d   = push;
    cs_d    = cs_q;
    wrn_d   = wrn_q;
    dout_d  = dout_q;
    done_d  = 1'b0;
    pop     = 1'b0;
    if (push) begin
      mem_d[wp_q] = bus.rom_data;
      wp_d        = ~wp_q;
      addr_d      = addr_q + 17'd1;
      fetch_d     = fetch_q - 17'd1;
    end
    if (cen) begin
      case (state_q)
        ST_IDLE: if (start) begin
          if (len == 17'd0) done_d = 1'b1;
          else begin
            state_d = ST_ARM;
            addr_d  = start_addr;
            fetch_d = len;
            send_d  = len;
          end
        end
        ST_ARM: if (!bus.drqn && cnt_q != 2'd0) begin
          pop     = 1'b1;
          dout_d  = mem_q[rp_q];
          rp_d    = ~rp_q;
          cs_d    = 1'b1;
          wrn_d   = 1'b0;
          strb_d  = 4'(STRB);
          state_d = ST_STRB;
        end
        ST_STRB: begin
          strb_d = strb_q - 4'd1;
          if (strb_q == 4'd1) begin
            cs_d    = 1'b0;
            wrn_d   = 1'b1;
            send_d  = send_q - 17'd1;
            done_d  = send_q == 17'd1;
            state_d = send_q == 17'd1 ? ST_IDLE : ST_REL;
          end
        end
        ST_REL: if (bus.drqn) state_d = ST_ARM;
      endcase
    end
    cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
    if (stop) begin
      state_d = ST_IDLE;
      fetch_d = 17'd0;
      send_d  = 17'd0;
      strb_d  = 4'd0;
      wp_d    = 1'b0;
      rp_d    = 1'b0;
      cnt_d   = 2'd0;
      cap_d   = 1'b0;
      cs_d    = 1'b0;
      wrn_d   = 1'b1;
      done_d  = 1'b0;
    end
  end
  // state register with asynchronous active-low reset
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      fetch_q <= 17'd0;
      send_q  <= 17'd0;
      addr_q  <= 17'd0;
      strb_q  <= 4'd0;
      mem_q   <= '{default: 8'd0};
      wp_q    <= 1'b0;
      rp_q    <= 1'b0;
      cnt_q   <= 2'd0;
      cap_q   <= 1'b0;
      cs_q    <= 1'b0;
      wrn_q   <= 1'b1;
      dout_q  <= 8'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      fetch_q <= fetch_d;
      send_q  <= send_d;
      addr_q  <= addr_d;
      strb_q  <= strb_d;
      mem_q   <= mem_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      cnt_q   <= cnt_d;
      cap_q   <= cap_d;
      cs_q    <= cs_d;
      wrn_q   <= wrn_d;
      dout_q  <= dout_d;
      done_q  <= done_d;
    end
  end
endmodule

// File: tb/tb_jt7759_feeder.sv
// tb_jt7759_feeder: scoreboard bench, expected bytes queued at start, strobes checked by a monitor
module tb_jt7759_feeder;
  localparam int STRB = 4;
  logic        clk = 0, rstn = 0, cen = 0, start = 0, stop = 0, late_ok = 0;
  logic [16:0] start_addr = '0, len = '0;
  logic        busy, done;
  int          rom_lat = 0, lat_cnt = 0;
  int          checks = 0, errors = 0, strobes = 0, dones = 0, rise_done = 0;
  int          width = 0, s0, d0, r0;
  logic        act, act_p = 0, stable = 1, aborting = 0;
  logic [7:0]  sd, e;
  logic [7:0]  exp_q [$];

  jt7759_feeder_if bus();

  jt7759_feeder #(.STRB(STRB)) dut (
    .clk(clk), .rstn(rstn), .cen(cen), .start(start), .stop(stop),
    .start_addr(start_addr), .len(len), .busy(busy), .done(done), .bus(bus)
  );

  function automatic logic [7:0] rom_byte(input logic [16:0] a);
    return a[7:0] ^ (a[16] ? 8'hC3 : 8'h5A);
  endfunction

  always #5 clk = ~clk;
  always @(negedge clk) cen = ~cen;

  assign bus.rom_data = rom_byte(bus.rom_addr);
  assign bus.rom_ok   = late_ok | (bus.rom_cs && lat_cnt >= rom_lat);
  always @(posedge clk) lat_cnt <= bus.rom_cs ? lat_cnt + 1 : 0;

  task automatic check(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
    checks++;
    if (act_v !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act_v, exp_v);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic go(input logic [16:0] a, input logic [16:0] l);
    for (int i = 0; i < int'(l); i++) exp_q.push_back(rom_byte(a + 17'(i)));
    start_addr = a;
    len = l;
    start = 1;
    tick(2);
    start = 0;
  endtask

  task automatic wait_cs(input int lim);
    int k = 0;
    while (!bus.cs && k < lim) begin tick(1); k++; end
    check("wait_cs", bus.cs, 1);
  endtask

  task automatic wait_idle(input int lim);
    int k = 0;
    while (busy && k < lim) begin tick(1); k++; end
    check("wait_idle", busy, 0);
  endtask

  task automatic serve(input int n);
    repeat (n) begin
      tick(80);
      bus.drqn = 0;
      wait_cs(400);
      bus.drqn = 1;
    end
  endtask

  always @(negedge clk) begin
    act = bus.cs && !bus.wrn;
    if (act && !act_p) begin
      strobes++;
      width = 1;
      stable = 1;
      sd = bus.dout;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL strobe_extra: got byte %0h expected no strobe", bus.dout);
      end else begin
        e = exp_q.pop_front();
        check("strobe_byte", bus.dout, e);
      end
    end else if (act) begin
      width++;
      if (bus.dout !== sd) stable = 0;
    end
    if (!act && act_p && !aborting) begin
      check("strobe_width", width, 2 * STRB);
      check("dout_stable", stable, 1);
    end
    if (done) begin
      dones++;
      if (!act && act_p) rise_done++;
    end
    act_p = act;
  end

  initial begin
    bus.drqn = 1;
    tick(3);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rom_cs", bus.rom_cs, 0);
    check("rst_rom_addr", bus.rom_addr, 0);
    check("rst_cs", bus.cs, 0);
    check("rst_wrn", bus.wrn, 1);
    check("rst_dout", bus.dout, 0);
    rstn = 1;
    tick(2);
    // basic stream
    s0 = strobes; d0 = dones; r0 = rise_done;
    go(17'h00100, 17'd3);
    serve(3);
    wait_idle(200);
    tick(2);
    check("basic_strobes", strobes - s0, 3);
    check("basic_done", dones - d0, 1);
    check("basic_done_rise", rise_done - r0, 1);
    check("basic_rom_addr", bus.rom_addr, 17'h00103);
    check("basic_left", exp_q.size(), 0);
    // slow ROM, drqn held low
    rom_lat = 20;
    s0 = strobes;
    bus.drqn = 0;
    go(17'h00200, 17'd1);
    tick(15);
    check("slow_no_early", strobes - s0, 0);
    check("slow_cs_low", bus.cs, 0);
    wait_idle(300);
    bus.drqn = 1;
    tick(2);
    check("slow_strobes", strobes - s0, 1);
    check("slow_rom_addr", bus.rom_addr, 17'h00201);
    check("slow_left", exp_q.size(), 0);
    rom_lat = 0;
    // long request
    s0 = strobes; d0 = dones;
    go(17'h00300, 17'd2);
    tick(10);
    bus.drqn = 0;
    wait_cs(400);
    tick(60);
    check("long_single", strobes - s0, 1);
    bus.drqn = 1;
    tick(4);
    bus.drqn = 0;
    wait_cs(400);
    bus.drqn = 1;
    wait_idle(200);
    tick(2);
    check("long_strobes", strobes - s0, 2);
    check("long_done", dones - d0, 1);
    // len = 0
    s0 = strobes; d0 = dones;
    go(17'h00010, 17'd0);
    tick(3);
    check("len0_done", dones - d0, 1);
    check("len0_strobes", strobes - s0, 0);
    check("len0_busy", busy, 0);
    // address wrap
    go(17'h1FFFF, 17'd2);
    serve(2);
    wait_idle(200);
    tick(2);
    check("wrap_left", exp_q.size(), 0);
    check("wrap_rom_addr", bus.rom_addr, 17'h00001);
    // abort during second of four bytes
    d0 = dones;
    go(17'h00400, 17'd4);
    serve(1);
    tick(80);
    bus.drqn = 0;
    wait_cs(400);
    aborting = 1;
    tick(2);
    stop = 1;
    tick(1);
    stop = 0;
    check("abort_busy", busy, 0);
    check("abort_cs", bus.cs, 0);
    check("abort_wrn", bus.wrn, 1);
    check("abort_rom_cs", bus.rom_cs, 0);
    bus.drqn = 1;
    late_ok = 1;
    tick(3);
    late_ok = 0;
    check("abort_no_done", dones - d0, 0);
    check("abort_still_idle", busy, 0);
    exp_q.delete();
    aborting = 0;
    s0 = strobes; d0 = dones;
    go(17'h00500, 17'd2);
    serve(2);
    wait_idle(200);
    tick(2);
    check("restart_strobes", strobes - s0, 2);
    check("restart_done", dones - d0, 1);
    check("restart_rom_addr", bus.rom_addr, 17'h00502);
    check("restart_left", exp_q.size(), 0);
    // asynchronous reset mid-strobe
    go(17'h00600, 17'd2);
    bus.drqn = 0;
    wait_cs(400);
    aborting = 1;
    tick(1);
    rstn = 0;
    #1;
    check("arst_cs", bus.cs, 0);
    check("arst_wrn", bus.wrn, 1);
    check("arst_busy", busy, 0);
    check("arst_rom_cs", bus.rom_cs, 0);
    check("arst_rom_addr", bus.rom_addr, 0);
    exp_q.delete();
    bus.drqn = 1;
    tick(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
